// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter: framebuffer geometry,
// bus widths, the per-cycle grant encoding and the queued-write entry layout.
package fb_pkg;

    localparam int FB_W     = 240;
    localparam int FB_H     = 160;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int ADDR_W   = 16;
    localparam int PIX_W    = 15;
    localparam int ENTRY_W  = ADDR_W + PIX_W;

    // Who owns the RAM port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

    // One queued PPU write; address in the upper bits, pixel in the lower.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_entry_t;

    // Plain 16-bit unsigned range check; no wrap or remap of the address.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                        input int unsigned      words);
        return 32'(addr) < words;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO for PPU pixel writes. Show-ahead: the head entry is
// visible combinationally so the arbiter can drive it to the RAM in the same
// cycle it decides to pop. Pushes when full and pops when empty are ignored.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic                        i_clock50,
    input  logic                        i_reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer update; depth is a power of two so the pointers wrap for free.
    always_ff @(posedge i_clock50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge i_clock50) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // cleared pointers already mark every entry as invalid, and leaving
        // it unreset lets it map onto plain RAM.
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Occupancy: simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter. Scanout reads always win the single RAM port
// and return with a fixed two-cycle latency; PPU writes are queued and
// drained into cycles the scanout leaves idle. Flags report dropped
// out-of-range writes and writes that sat blocked for too long.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int FB_WORDS     = fb_pkg::FB_WORDS,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        i_clock50,
    input  logic                        i_reset,
    // scanout read side
    input  logic                        i_rd_req,
    input  logic [15:0]                 i_rdaddr,
    output logic [14:0]                 o_rd_data,
    output logic                        o_rd_valid,
    // PPU write side
    input  logic                        i_wr_valid,
    input  logic [15:0]                 i_wr_addr,
    input  logic [14:0]                 i_wr_data,
    output logic                        o_wr_ready,
    // RAM macro side
    output logic [15:0]                 o_ram_addr,
    output logic                        o_ram_we,
    output logic [14:0]                 o_ram_wdata,
    input  logic [14:0]                 i_ram_rdata,
    // status
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_addr_err,
    output logic                        o_starve
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    grant_t               grant_d;
    grant_t               grant_q;
    wr_entry_t            push_entry;
    wr_entry_t            head_entry;
    logic [ENTRY_W-1:0]   head_bits;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 wr_accept;
    logic                 wr_legal;
    logic                 fifo_push;
    logic                 rd_pend;
    logic [STARVE_W-1:0]  starve_cnt;

    // ------------------------------------------------------------------
    // Write intake: out-of-range beats are acknowledged but never stored.
    // ------------------------------------------------------------------
    assign o_wr_ready      = !fifo_full;
    assign wr_accept       = i_wr_valid && o_wr_ready;
    assign wr_legal        = addr_legal(i_wr_addr, FB_WORDS);
    assign fifo_push       = wr_accept && wr_legal;
    assign push_entry.addr = i_wr_addr;
    assign push_entry.data = i_wr_data;
    assign head_entry      = wr_entry_t'(head_bits);

    fb_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_wr_fifo (
        .i_clock50 (i_clock50),
        .i_reset   (i_reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_bits),
        .level     (o_fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Grant decision: scanout first, then the write queue, else idle.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default every always_comb output first so no path through
        // the block leaves it unassigned and infers a latch.
        grant_d = GNT_NONE;
        if (i_rd_req) begin
            grant_d = GNT_RD;
        end else if (!fifo_empty) begin
            grant_d = GNT_WR;
        end
    end

    assign fifo_pop = (grant_d == GNT_WR);

    // Grant state register; feeds the read-return pipeline.
    always_ff @(posedge i_clock50) begin
        if (i_reset) grant_q <= GNT_NONE;
        else         grant_q <= grant_d;
    end

    // Registered RAM pins; the address holds through idle cycles.
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
        end else begin
            case (grant_d)
                GNT_RD: begin
                    o_ram_addr <= i_rdaddr;
                    o_ram_we   <= 1'b0;
                end
                GNT_WR: begin
                    o_ram_addr  <= head_entry.addr;
                    o_ram_wdata <= head_entry.data;
                    o_ram_we    <= 1'b1;
                end
                default: begin
                    o_ram_we <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read return: the RAM answers one cycle after the address appears on
    // its pins, so capture happens two edges after the request is sampled.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            rd_pend    <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_pend    <= (grant_q == GNT_RD);
            o_rd_valid <= rd_pend;
            if (rd_pend) o_rd_data <= i_ram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Sticky address-error flag for dropped out-of-range writes.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock50) begin
        if (i_reset)                    o_addr_err <= 1'b0;
        else if (wr_accept && !wr_legal) o_addr_err <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Starvation watch: counts reads that block a non-empty queue, clears
    // whenever a write drains, saturates and latches o_starve at the limit.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            starve_cnt <= '0;
            o_starve   <= 1'b0;
        end else if (grant_d == GNT_WR) begin
            starve_cnt <= '0;
        end else if (grant_d == GNT_RD && !fifo_empty) begin
            if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (starve_cnt >= STARVE_W'(STARVE_LIMIT - 1)) begin
                o_starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter. Inputs are driven 1 ns after each
// rising edge and outputs are observed at the same point, so an observation
// taken after the tick that closes cycle s shows the registers updated by
// that edge. The RAM model returns addr[14:0] one cycle after the address.
module tb_fb_port_arbiter;

    logic        i_clock50 = 1'b0;
    logic        i_reset;
    logic        i_rd_req;
    logic [15:0] i_rdaddr;
    logic [14:0] o_rd_data;
    logic        o_rd_valid;
    logic        i_wr_valid;
    logic [15:0] i_wr_addr;
    logic [14:0] i_wr_data;
    logic        o_wr_ready;
    logic [15:0] o_ram_addr;
    logic        o_ram_we;
    logic [14:0] o_ram_wdata;
    logic [14:0] i_ram_rdata;
    logic [3:0]  o_fifo_level;
    logic        o_addr_err;
    logic        o_starve;

    int checks = 0;
    int errors = 0;
    logic [30:0] wr_log [$];

    always #10 i_clock50 = ~i_clock50;

    always @(posedge i_clock50) i_ram_rdata <= o_ram_addr[14:0];

    fb_port_arbiter #(
        .FIFO_DEPTH   (8),
        .FB_WORDS     (38400),
        .STARVE_LIMIT (64)
    ) dut (
        .i_clock50    (i_clock50),
        .i_reset      (i_reset),
        .i_rd_req     (i_rd_req),
        .i_rdaddr     (i_rdaddr),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .i_wr_valid   (i_wr_valid),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_ram_addr   (o_ram_addr),
        .o_ram_we     (o_ram_we),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (i_ram_rdata),
        .o_fifo_level (o_fifo_level),
        .o_addr_err   (o_addr_err),
        .o_starve     (o_starve)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle and log any RAM write visible on the pins.
    task automatic tick();
        @(posedge i_clock50);
        #1;
        if (o_ram_we === 1'b1) wr_log.push_back({o_ram_addr, o_ram_wdata});
    endtask

    task automatic idle_inputs();
        i_rd_req   = 1'b0;
        i_rdaddr   = '0;
        i_wr_valid = 1'b0;
        i_wr_addr  = '0;
        i_wr_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        wr_log.delete();
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        i_reset    = 1'b1;
        i_rd_req   = 1'b1;
        i_rdaddr   = 16'h1234;
        i_wr_valid = 1'b1;
        i_wr_addr  = 16'd9;
        i_wr_data  = 15'h5555;
        tick();
        outs = {o_rd_data, o_rd_valid, o_ram_we, o_ram_addr, o_ram_wdata,
                o_fifo_level, o_addr_err, o_starve};
        checks++;
        if (outs !== 54'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: got %b expected 1", o_wr_ready);
        end
        idle_inputs();
        i_reset = 1'b0;
        repeat (3) tick();
        outs = {o_rd_data, o_rd_valid, o_ram_we, o_ram_addr, o_ram_wdata,
                o_fifo_level, o_addr_err, o_starve};
        checks++;
        if (outs !== 54'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h expected 0", outs);
        end
        wr_log.delete();
    endtask

    task automatic test_write_burst();
        logic [14:0] pix [4];
        logic [3:0]  exp_lvl;
        logic        exp_we;
        pix[0] = 15'h7FFF;
        pix[1] = 15'h001F;
        pix[2] = 15'h03E0;
        pix[3] = 15'h7C00;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            idle_inputs();
            if (s < 4) begin
                i_wr_valid = 1'b1;
                i_wr_addr  = 16'(s);
                i_wr_data  = pix[s];
            end
            tick();
            exp_lvl = (s <= 3) ? 4'd1 : 4'd0;
            exp_we  = (s >= 1 && s <= 4);
            checks++;
            if (o_fifo_level !== exp_lvl) begin
                errors++;
                $display("FAIL burst_level[%0d]: got %0d expected %0d", s, o_fifo_level, exp_lvl);
            end
            checks++;
            if (o_ram_we !== exp_we) begin
                errors++;
                $display("FAIL burst_we[%0d]: got %b expected %b", s, o_ram_we, exp_we);
            end
            if (exp_we) begin
                checks++;
                if ({o_ram_addr, o_ram_wdata} !== {16'(s - 1), pix[s-1]}) begin
                    errors++;
                    $display("FAIL burst_ram[%0d]: got %h/%h expected %h/%h", s,
                             o_ram_addr, o_ram_wdata, 16'(s - 1), pix[s-1]);
                end
            end
        end
        checks++;
        if (wr_log.size() != 4) begin
            errors++;
            $display("FAIL burst_count: got %0d expected 4", wr_log.size());
        end
    endtask

    task automatic test_alt_reads();
        logic        exp_valid;
        logic [15:0] k;
        do_reset();
        for (int s = 0; s < 14; s++) begin
            idle_inputs();
            if (s < 12 && (s % 2) == 0) begin
                i_rd_req   = 1'b1;
                i_rdaddr   = 16'(100 + s / 2);
                i_wr_valid = 1'b1;
                i_wr_addr  = 16'(200 + s / 2);
                i_wr_data  = 15'(16'h1000 + s / 2);
            end
            tick();
            exp_valid = (s >= 2 && s <= 12 && (s % 2) == 0);
            checks++;
            if (o_rd_valid !== exp_valid) begin
                errors++;
                $display("FAIL alt_rd_valid[%0d]: got %b expected %b", s, o_rd_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (o_rd_data !== 15'(100 + (s - 2) / 2)) begin
                    errors++;
                    $display("FAIL alt_rd_data[%0d]: got %0d expected %0d", s, o_rd_data, 100 + (s - 2) / 2);
                end
            end else if (s >= 3 && s <= 11) begin
                checks++;
                if (o_rd_data !== 15'(100 + (s - 3) / 2)) begin
                    errors++;
                    $display("FAIL alt_rd_hold[%0d]: got %0d expected %0d", s, o_rd_data, 100 + (s - 3) / 2);
                end
            end
            if (s < 12) begin
                if ((s % 2) == 0) begin
                    k = 16'(100 + s / 2);
                    checks++;
                    if ({o_ram_we, o_ram_addr} !== {1'b0, k}) begin
                        errors++;
                        $display("FAIL alt_rd_pins[%0d]: got we=%b addr=%0d expected we=0 addr=%0d",
                                 s, o_ram_we, o_ram_addr, k);
                    end
                end else begin
                    k = 16'(200 + (s - 1) / 2);
                    checks++;
                    if ({o_ram_we, o_ram_addr, o_ram_wdata} !== {1'b1, k, 15'(16'h1000 + (s - 1) / 2)}) begin
                        errors++;
                        $display("FAIL alt_wr_pins[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d",
                                 s, o_ram_we, o_ram_addr, o_ram_wdata, k);
                    end
                end
                checks++;
                if (o_fifo_level !== (((s % 2) == 0) ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL alt_level[%0d]: got %0d", s, o_fifo_level);
                end
            end
        end
    endtask

    task automatic test_starve();
        do_reset();
        i_rd_req = 1'b1;
        i_rdaddr = 16'd0;
        for (int i = 0; i < 9; i++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = 16'(300 + i);
            i_wr_data  = 15'(16'h2000 + i);
            checks++;
            if (o_wr_ready !== (i < 8)) begin
                errors++;
                $display("FAIL starve_ready[%0d]: got %b expected %b", i, o_wr_ready, (i < 8));
            end
            tick();
        end
        i_wr_valid = 1'b0;
        checks++;
        if ({o_fifo_level, o_wr_ready} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL starve_full: got level=%0d ready=%b expected level=8 ready=0", o_fifo_level, o_wr_ready);
        end
        repeat (55) tick();
        checks++;
        if (o_starve !== 1'b0) begin
            errors++;
            $display("FAIL starve_early: got %b expected 0 after 63 blocked cycles", o_starve);
        end
        tick();
        checks++;
        if (o_starve !== 1'b1) begin
            errors++;
            $display("FAIL starve_set: got %b expected 1 after 64 blocked cycles", o_starve);
        end
        checks++;
        if (wr_log.size() != 0) begin
            errors++;
            $display("FAIL starve_no_write: got %0d writes expected 0", wr_log.size());
        end
        i_rd_req = 1'b0;
        repeat (12) tick();
        checks++;
        if ({o_fifo_level, o_starve} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL starve_drain: got level=%0d starve=%b expected level=0 starve=1", o_fifo_level, o_starve);
        end
        checks++;
        if (wr_log.size() != 8) begin
            errors++;
            $display("FAIL starve_count: got %0d expected 8", wr_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_log[i] !== {16'(300 + i), 15'(16'h2000 + i)}) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got %h expected %h", i, wr_log[i],
                             {16'(300 + i), 15'(16'h2000 + i)});
                end
            end
        end
    endtask

    task automatic test_addr_err();
        do_reset();
        checks++;
        if (o_addr_err !== 1'b0) begin
            errors++;
            $display("FAIL err_initial: got %b expected 0", o_addr_err);
        end
        i_wr_valid = 1'b1;
        i_wr_addr  = 16'd38400;
        i_wr_data  = 15'h0001;
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_ready: got %b expected 1", o_wr_ready);
        end
        tick();
        checks++;
        if ({o_addr_err, o_fifo_level} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL err_drop: got err=%b level=%0d expected err=1 level=0", o_addr_err, o_fifo_level);
        end
        i_wr_addr = 16'd5;
        i_wr_data = 15'h1234;
        tick();
        i_wr_addr = 16'd38399;
        i_wr_data = 15'h4321;
        tick();
        idle_inputs();
        repeat (5) tick();
        checks++;
        if (wr_log.size() != 2) begin
            errors++;
            $display("FAIL err_count: got %0d expected 2", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[0], wr_log[1]} !== {16'd5, 15'h1234, 16'd38399, 15'h4321}) begin
                errors++;
                $display("FAIL err_writes: got %h %h expected addr 5 then 38399", wr_log[0], wr_log[1]);
            end
        end
        checks++;
        if (o_addr_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", o_addr_err);
        end
        do_reset();
        checks++;
        if (o_addr_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", o_addr_err);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        i_rd_req = 1'b1;
        i_rdaddr = 16'd7;
        for (int i = 0; i < 5; i++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = 16'(400 + i);
            i_wr_data  = 15'(i);
            tick();
        end
        checks++;
        if (o_fifo_level !== 4'd5) begin
            errors++;
            $display("FAIL midop_level: got %0d expected 5", o_fifo_level);
        end
        i_wr_valid = 1'b0;
        i_reset    = 1'b1;
        tick();
        checks++;
        if ({o_fifo_level, o_rd_valid, o_ram_we} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: got level=%0d rd_valid=%b we=%b expected 0/0/0",
                     o_fifo_level, o_rd_valid, o_ram_we);
        end
        i_reset = 1'b0;
        idle_inputs();
        wr_log.delete();
        for (int s = 0; s < 6; s++) begin
            tick();
            checks++;
            if (o_rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_stale_read[%0d]: got %b expected 0", s, o_rd_valid);
            end
        end
        checks++;
        if (wr_log.size() != 0) begin
            errors++;
            $display("FAIL midop_stale_write: got %0d writes expected 0", wr_log.size());
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = 16'(500 + i);
            i_wr_data  = 15'(16'h3000 + i);
            tick();
        end
        checks++;
        if (o_fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL full_level: got %0d expected 8", o_fifo_level);
        end
        i_rd_req  = 1'b0;
        i_wr_addr = 16'd600;
        i_wr_data = 15'h3600;
        checks++;
        if (o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: got ready=%b expected 0", o_wr_ready);
        end
        tick();
        checks++;
        if (o_fifo_level !== 4'd7) begin
            errors++;
            $display("FAIL full_pop_only: got %0d expected 7", o_fifo_level);
        end
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: got ready=%b expected 1", o_wr_ready);
        end
        tick();
        checks++;
        if (o_fifo_level !== 4'd7) begin
            errors++;
            $display("FAIL full_push_pop: got %0d expected 7", o_fifo_level);
        end
        idle_inputs();
        repeat (12) tick();
        checks++;
        if (wr_log.size() != 9) begin
            errors++;
            $display("FAIL full_count: got %0d expected 9", wr_log.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_log[i] !== ((i < 8) ? {16'(500 + i), 15'(16'h3000 + i)} : {16'd600, 15'h3600})) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got %h", i, wr_log[i]);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        test_reset();
        test_write_burst();
        test_alt_reads();
        test_starve();
        test_addr_err();
        test_reset_midop();
        test_full_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
